nios_status_pio_irq: RTL and testbench

Parametrised Avalon-MM slave input port for Nios status lines, WIDTH bits wide. Extends a plain read-only status PIO with:
- input synchronisation
- per-bit edge capture, cleared by writing 1 to the bit
- per-bit interrupt mask
- a single irq output to the Nios interrupt controller

Software polls the status lines or takes interrupts on them, for example drawing-engine done/busy flags.

---
 rtl/nios_status_pio_irq.sv | 106 ++++++++++
 tb/tb_nios_status_pio_irq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nios_status_pio_irq.sv
// rtl/nios_status_pio_irq.sv - Avalon-MM status input PIO with edge capture, irq mask and irq output
module nios_status_pio_irq #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_irqmask;
  logic [WIDTH-1:0]                  r_edgecap;
  logic [31:0]                       r_readdata;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_det;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_mux;
  logic             w_wr;
  logic             w_unused_wdata;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_sync & ~r_prev;
  assign w_fall  = ~w_sync & r_prev;
  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[WIDTH-1:0];
  assign w_clr   = (w_wr && address == 2'd2) ? w_wdata : '0;

  // Only the low WIDTH bits of writedata are architecturally meaningful.
  assign w_unused_wdata = ^writedata;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign w_det = w_rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign w_det = w_fall;
    end else begin : g_any
      assign w_det = w_rise | w_fall;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
      r_prev <= w_sync;
    end
  end

  // A fresh edge outranks a software clear on the same cycle so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
      r_irqmask <= '0;
    end else begin
      r_edgecap <= w_det | (r_edgecap & ~w_clr);
      if (w_wr && address == 2'd1) begin
        r_irqmask <= w_wdata;
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux[WIDTH-1:0] = w_sync;
      2'd1:    w_rd_mux[WIDTH-1:0] = r_irqmask;
      2'd2:    w_rd_mux[WIDTH-1:0] = r_edgecap;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;

  generate
    if (IRQ_MODE == 1) begin : g_irq_edge
      assign irq = |(r_edgecap & r_irqmask);
    end else begin : g_irq_level
      assign irq = |(w_sync & r_irqmask);
    end
  endgenerate

endmodule

// File: tb/tb_nios_status_pio_irq.sv
// tb/tb_nios_status_pio_irq.sv - directed vector bench for nios_status_pio_irq
module tb_nios_status_pio_irq;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs0, cs1, cs2;
  logic [1:0]  in0, in2;
  logic [7:0]  in1;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int n_checks;
  int n_errors;

  // u0: rising/edge irq, u1: 8-bit level irq, u2: any-edge
  nios_status_pio_irq #(.WIDTH(2), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0));
  nios_status_pio_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .in_port(in1), .irq(irq1));
  nios_status_pio_irq #(.WIDTH(2), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_MODE(1)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2), .write_n(write_n),
    .writedata(writedata), .readdata(rd2), .in_port(in2), .irq(irq2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [1:0]  pin;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[34];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one bus cycle and returns at the following negedge.
  task automatic bus(input logic [2:0] sel, input logic [1:0] a, input logic w, input logic [31:0] d);
    cs0       = sel[0];
    cs1       = sel[1];
    cs2       = sel[2];
    address   = a;
    write_n   = ~w;
    writedata = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    address   = 2'd0;
    write_n   = 1'b1;
    writedata = 32'd0;
    cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
    in0 = 2'b11; in1 = 8'h03; in2 = 2'b11;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b11, 32'd3, 1'b0};
    tbl[1]  = '{1'b1, 2'd2, 1'b1, 32'd3, 2'b00, 32'd3, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b00, 32'd0, 1'b0};
    tbl[3]  = '{1'b1, 2'd1, 1'b1, 32'd1, 2'b00, 32'd0, 1'b0};
    tbl[4]  = '{1'b1, 2'd1, 1'b0, 32'd0, 2'b01, 32'd1, 1'b0};
    tbl[5]  = '{1'b1, 2'd0, 1'b0, 32'd0, 2'b01, 32'd0, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 32'd0, 2'b01, 32'd1, 1'b1};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b01, 32'd1, 1'b1};
    tbl[8]  = '{1'b1, 2'd2, 1'b1, 32'd1, 2'b01, 32'd1, 1'b0};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b01, 32'd0, 1'b0};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b00, 32'd0, 1'b0};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b00, 32'd0, 1'b0};
    tbl[12] = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b01, 32'd0, 1'b0};
    tbl[13] = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b01, 32'd0, 1'b0};
    tbl[14] = '{1'b1, 2'd2, 1'b1, 32'd1, 2'b01, 32'd0, 1'b1};
    tbl[15] = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b01, 32'd1, 1'b1};
    tbl[16] = '{1'b1, 2'd2, 1'b1, 32'd1, 2'b11, 32'd1, 1'b0};
    tbl[17] = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b11, 32'd0, 1'b0};
    tbl[18] = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b11, 32'd0, 1'b0};
    tbl[19] = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b11, 32'd2, 1'b0};
    tbl[20] = '{1'b1, 2'd1, 1'b1, 32'd3, 2'b11, 32'd1, 1'b1};
    tbl[21] = '{1'b1, 2'd1, 1'b1, 32'hFFFF_FFFD, 2'b11, 32'd3, 1'b0};
    tbl[22] = '{1'b1, 2'd1, 1'b0, 32'd0, 2'b11, 32'd1, 1'b0};
    tbl[23] = '{1'b1, 2'd1, 1'b1, 32'd2, 2'b11, 32'd1, 1'b1};
    tbl[24] = '{1'b1, 2'd3, 1'b1, 32'hFFFF_FFFF, 2'b11, 32'd0, 1'b1};
    tbl[25] = '{1'b1, 2'd0, 1'b1, 32'd0, 2'b11, 32'd3, 1'b1};
    tbl[26] = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b01, 32'd2, 1'b1};
    tbl[27] = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b11, 32'd2, 1'b1};
    tbl[28] = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b11, 32'd2, 1'b1};
    tbl[29] = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b11, 32'd2, 1'b1};
    tbl[30] = '{1'b1, 2'd2, 1'b1, 32'd2, 2'b11, 32'd2, 1'b0};
    tbl[31] = '{1'b1, 2'd2, 1'b0, 32'd0, 2'b11, 32'd0, 1'b0};
    tbl[32] = '{1'b0, 2'd1, 1'b1, 32'd3, 2'b11, 32'd2, 1'b0};
    tbl[33] = '{1'b1, 2'd1, 1'b0, 32'd0, 2'b11, 32'd2, 1'b0};

    // Reset with inputs high, then release and watch the pending rising edges arrive.
    repeat (3) @(negedge clk);
    chk("reset_rd0", rd0, 32'd0);
    chk("reset_irq0", {31'd0, irq0}, 32'd0);
    reset_n = 1'b1;
    bus(3'b001, 2'd0, 1'b0, 32'd0);
    chk("post_reset_e1_rd", rd0, 32'd0);
    bus(3'b001, 2'd0, 1'b0, 32'd0);
    chk("post_reset_e2_rd", rd0, 32'd0);
    bus(3'b001, 2'd0, 1'b0, 32'd0);
    chk("post_reset_data", rd0, 32'd3);

    for (int i = 0; i < 34; i++) begin
      in0 = tbl[i].pin;
      bus({2'b00, tbl[i].cs}, tbl[i].addr, tbl[i].wr, tbl[i].wdata);
      chk($sformatf("vec%0d_rd", i), rd0, tbl[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq0}, {31'd0, tbl[i].exp_irq});
    end

    // Level mode, 8 bits wide.
    in1 = 8'h10;
    bus(3'b010, 2'd1, 1'b1, 32'hFFFF_FFF0);
    chk("lvl_irq_wait", {31'd0, irq1}, 32'd0);
    bus(3'b010, 2'd1, 1'b0, 32'd0);
    chk("lvl_irq_set", {31'd0, irq1}, 32'd1);
    chk("lvl_mask_rd", rd1, 32'h0000_00F0);
    bus(3'b010, 2'd0, 1'b0, 32'd0);
    chk("lvl_data_10", rd1, 32'h0000_0010);
    bus(3'b010, 2'd3, 1'b0, 32'd0);
    chk("lvl_rsvd", rd1, 32'd0);
    in1 = 8'h00;
    bus(3'b010, 2'd0, 1'b0, 32'd0);
    chk("lvl_irq_hold", {31'd0, irq1}, 32'd1);
    bus(3'b010, 2'd0, 1'b0, 32'd0);
    chk("lvl_irq_clr", {31'd0, irq1}, 32'd0);
    bus(3'b010, 2'd0, 1'b0, 32'd0);
    chk("lvl_data_00", rd1, 32'd0);
    in1 = 8'h0F;
    bus(3'b010, 2'd0, 1'b0, 32'd0);
    bus(3'b010, 2'd0, 1'b0, 32'd0);
    bus(3'b010, 2'd0, 1'b0, 32'd0);
    chk("lvl_data_0f", rd1, 32'h0000_000F);
    chk("lvl_masked_irq", {31'd0, irq1}, 32'd0);

    // Any-edge mode: settle, clear, then pulse bit 1 up and down.
    in2 = 2'b00;
    repeat (4) bus(3'b100, 2'd2, 1'b0, 32'd0);
    bus(3'b100, 2'd2, 1'b1, 32'd3);
    bus(3'b100, 2'd1, 1'b1, 32'd2);
    bus(3'b100, 2'd2, 1'b0, 32'd0);
    chk("any_clr_rd", rd2, 32'd0);
    chk("any_clr_irq", {31'd0, irq2}, 32'd0);
    in2 = 2'b10;
    bus(3'b100, 2'd2, 1'b0, 32'd0);
    bus(3'b100, 2'd2, 1'b0, 32'd0);
    chk("any_rise_e2_irq", {31'd0, irq2}, 32'd0);
    bus(3'b100, 2'd2, 1'b0, 32'd0);
    chk("any_rise_irq", {31'd0, irq2}, 32'd1);
    bus(3'b100, 2'd2, 1'b0, 32'd0);
    chk("any_rise_rd", rd2, 32'd2);
    bus(3'b100, 2'd2, 1'b1, 32'd2);
    chk("any_rise_clr_irq", {31'd0, irq2}, 32'd0);
    in2 = 2'b00;
    bus(3'b100, 2'd2, 1'b0, 32'd0);
    bus(3'b100, 2'd2, 1'b0, 32'd0);
    bus(3'b100, 2'd2, 1'b0, 32'd0);
    chk("any_fall_irq", {31'd0, irq2}, 32'd1);
    bus(3'b100, 2'd2, 1'b0, 32'd0);
    chk("any_fall_rd", rd2, 32'd2);

    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_rd2", rd2, 32'd0);
    chk("async_rst_irq2", {31'd0, irq2}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
